// File: rtl/clint_pkg.sv
// Shared constants, types and helpers for the core-local interrupt sequencer.
// Imported by the interface, the request decoder and the top.
package clint_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned IRQ_W   = 8;
    localparam int unsigned STATE_W = 7;

    typedef enum logic [CSR_AW-1:0] {
        CSR_MSTATUS = 12'h300,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342
    } csr_addr_e;

    localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] INST_MRET   = 32'h3020_0073;

    localparam logic [XLEN-1:0] DEF_CAUSE_ECALL  = 32'd11;
    localparam logic [XLEN-1:0] DEF_CAUSE_EBREAK = 32'd3;
    localparam logic [XLEN-1:0] DEF_CAUSE_EXT    = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    // One-hot sequencer states
    localparam logic [STATE_W-1:0] S_IDLE         = 7'b000_0001;
    localparam logic [STATE_W-1:0] S_MEPC         = 7'b000_0010;
    localparam logic [STATE_W-1:0] S_MSTATUS      = 7'b000_0100;
    localparam logic [STATE_W-1:0] S_MCAUSE       = 7'b000_1000;
    localparam logic [STATE_W-1:0] S_ASSERT       = 7'b001_0000;
    localparam logic [STATE_W-1:0] S_MSTATUS_MRET = 7'b010_0000;
    localparam logic [STATE_W-1:0] S_ASSERT_MRET  = 7'b100_0000;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_SYNC  = 2'd1,
        REQ_MRET  = 2'd2,
        REQ_ASYNC = 2'd3
    } req_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] waddr;
        logic [XLEN-1:0] data;
    } csr_wr_t;

    function automatic csr_wr_t csr_write(input csr_addr_e addr, input logic [XLEN-1:0] data);
        csr_wr_t w;
        w.we    = 1'b1;
        w.waddr = XLEN'(addr);
        w.data  = data;
        return w;
    endfunction

    // Trap entry: stash MIE into MPIE and disable interrupts
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r               = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE
    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Bundle of id/ex, CSR-file and ctrl signals seen by the interrupt sequencer.
// master = sequencer side, slave = surrounding pipeline side.
interface clint_if;
    import clint_pkg::*;

    logic [IRQ_W-1:0] int_flag_i;
    logic [XLEN-1:0]  inst_i;
    logic [XLEN-1:0]  inst_addr_i;
    logic             jump_flag_i;
    logic [XLEN-1:0]  jump_addr_i;
    logic             div_started_i;
    logic [XLEN-1:0]  csr_mtvec_i;
    logic [XLEN-1:0]  csr_mepc_i;
    logic [XLEN-1:0]  csr_mstatus_i;
    logic             global_int_en_i;

    logic             we_o;
    logic [XLEN-1:0]  waddr_o;
    logic [XLEN-1:0]  data_o;
    logic             hold_flag_o;
    logic             int_assert_o;
    logic [XLEN-1:0]  int_addr_o;

    modport master (
        input  int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
        input  div_started_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
        output we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );

    modport slave (
        output int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
        output div_started_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
        input  we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );

endinterface

// File: rtl/clint_decode.sv
// Combinational trap/return/interrupt request decode with fixed priority
// SYNC > MRET > ASYNC; only produces a request while the sequencer is idle.
module clint_decode
    import clint_pkg::*;
#(
    parameter logic [XLEN-1:0] CAUSE_ECALL  = DEF_CAUSE_ECALL,
    parameter logic [XLEN-1:0] CAUSE_EBREAK = DEF_CAUSE_EBREAK,
    parameter logic [XLEN-1:0] CAUSE_EXT    = DEF_CAUSE_EXT
) (
    input  logic             idle,
    input  logic [XLEN-1:0]  inst,
    input  logic [XLEN-1:0]  inst_addr,
    input  logic [IRQ_W-1:0] int_flag,
    input  logic             jump_flag,
    input  logic [XLEN-1:0]  jump_addr,
    input  logic             div_started,
    input  logic             global_int_en,
    output req_e             req_c,
    output logic [XLEN-1:0]  cause_c,
    output logic [XLEN-1:0]  epc_c
);

    logic is_ecall;
    logic is_ebreak;
    logic is_mret;
    logic irq_pending;

    assign is_ecall    = (inst == INST_ECALL);
    assign is_ebreak   = (inst == INST_EBREAK);
    assign is_mret     = (inst == INST_MRET);
    assign irq_pending = (|int_flag) && global_int_en && !div_started;

    // An interrupt taken during a redirect must return to the redirect target
    always_comb begin
        req_c   = REQ_NONE;
        cause_c = '0;
        epc_c   = '0;
        if (idle) begin
            if (is_ecall) begin
                req_c   = REQ_SYNC;
                cause_c = CAUSE_ECALL;
                epc_c   = inst_addr;
            end else if (is_ebreak) begin
                req_c   = REQ_SYNC;
                cause_c = CAUSE_EBREAK;
                epc_c   = inst_addr;
            end else if (is_mret) begin
                req_c   = REQ_MRET;
            end else if (irq_pending) begin
                req_c   = REQ_ASYNC;
                cause_c = CAUSE_EXT;
                epc_c   = jump_flag ? jump_addr : inst_addr;
            end
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: stalls the pipeline, performs the
// mepc/mstatus/mcause save (or mstatus restore) and redirects to mtvec/mepc.
module clint
    import clint_pkg::*;
#(
    parameter logic [XLEN-1:0] CAUSE_ECALL  = DEF_CAUSE_ECALL,
    parameter logic [XLEN-1:0] CAUSE_EBREAK = DEF_CAUSE_EBREAK,
    parameter logic [XLEN-1:0] CAUSE_EXT    = DEF_CAUSE_EXT
) (
    input  logic     clk,
    input  logic     rst,
    clint_if.master  bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;

    req_e            req;
    logic [XLEN-1:0] dec_cause;
    logic [XLEN-1:0] dec_epc;

    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] epc_d;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] cause_d;

    csr_wr_t         wr_q;
    csr_wr_t         wr_d;
    logic            assert_q;
    logic            assert_d;
    logic [XLEN-1:0] int_addr_q;
    logic [XLEN-1:0] int_addr_d;

    clint_decode #(
        .CAUSE_ECALL   (CAUSE_ECALL),
        .CAUSE_EBREAK  (CAUSE_EBREAK),
        .CAUSE_EXT     (CAUSE_EXT)
    ) u_decode (
        .idle          (state == S_IDLE),
        .inst          (bus.inst_i),
        .inst_addr     (bus.inst_addr_i),
        .int_flag      (bus.int_flag_i),
        .jump_flag     (bus.jump_flag_i),
        .jump_addr     (bus.jump_addr_i),
        .div_started   (bus.div_started_i),
        .global_int_en (bus.global_int_en_i),
        .req_c         (req),
        .cause_c       (dec_cause),
        .epc_c         (dec_epc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the CSR write / redirect to present in the following cycle
    always_comb begin
        state_nx   = state;
        epc_d      = epc_q;
        cause_d    = cause_q;
        wr_d       = '0;
        assert_d   = 1'b0;
        int_addr_d = '0;
        case (state)
            S_IDLE: begin
                if ((req == REQ_SYNC) || (req == REQ_ASYNC)) begin
                    state_nx = S_MEPC;
                    epc_d    = dec_epc;
                    cause_d  = dec_cause;
                end else if (req == REQ_MRET) begin
                    state_nx = S_MSTATUS_MRET;
                end
            end
            S_MEPC: begin
                wr_d     = csr_write(CSR_MEPC, epc_q);
                state_nx = S_MSTATUS;
            end
            S_MSTATUS: begin
                wr_d     = csr_write(CSR_MSTATUS, mstatus_on_trap(bus.csr_mstatus_i));
                state_nx = S_MCAUSE;
            end
            S_MCAUSE: begin
                wr_d     = csr_write(CSR_MCAUSE, cause_q);
                state_nx = S_ASSERT;
            end
            S_ASSERT: begin
                assert_d   = 1'b1;
                int_addr_d = bus.csr_mtvec_i;
                state_nx   = S_IDLE;
            end
            S_MSTATUS_MRET: begin
                wr_d     = csr_write(CSR_MSTATUS, mstatus_on_mret(bus.csr_mstatus_i));
                state_nx = S_ASSERT_MRET;
            end
            S_ASSERT_MRET: begin
                assert_d   = 1'b1;
                int_addr_d = bus.csr_mepc_i;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_q      <= '0;
            cause_q    <= '0;
            wr_q       <= '0;
            assert_q   <= 1'b0;
            int_addr_q <= '0;
        end else begin
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            wr_q       <= wr_d;
            assert_q   <= assert_d;
            int_addr_q <= int_addr_d;
        end
    end

    // Hold is combinational so ex stalls in the very cycle a request is seen
    assign bus.hold_flag_o  = (state != S_IDLE) || (req != REQ_NONE);
    assign bus.we_o         = wr_q.we;
    assign bus.waddr_o      = wr_q.waddr;
    assign bus.data_o       = wr_q.data;
    assign bus.int_assert_o = assert_q;
    assign bus.int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: a directed vector table, hand-written
// reset/deferral/priority sequences and randomized transactions vs a model.
module tb_clint;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] EXT    = 32'h8000_000B;
    localparam int          WIN    = 9;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] inst_addr;
        logic [7:0]  int_flag;
        logic        mie;
        logic        div;
        logic        jump_flag;
        logic [31:0] jump_addr;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } stim_t;

    typedef struct {
        int               hold_cycles;
        int               nwr;
        logic [2:0][31:0] wa;
        logic [2:0][31:0] wd;
        int               first_wr;
        int               nassert;
        int               assert_cyc;
        logic [31:0]      assert_addr;
        int               leak;
    } res_t;

    typedef struct {
        stim_t s;
        res_t  e;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    clint_if bus();

    clint dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic stim_t st(input logic [31:0] inst, input logic [31:0] ia, input logic [7:0] irq,
                                 input logic mie, input logic div, input logic jf, input logic [31:0] ja,
                                 input logic [31:0] ms, input logic [31:0] tvec, input logic [31:0] mepc);
        stim_t s;
        s.inst = inst; s.inst_addr = ia; s.int_flag = irq; s.mie = mie; s.div = div;
        s.jump_flag = jf; s.jump_addr = ja; s.mstatus = ms; s.mtvec = tvec; s.mepc = mepc;
        return s;
    endfunction

    function automatic res_t blank();
        res_t r = '{default: 0};
        r.first_wr   = -1;
        r.assert_cyc = -1;
        return r;
    endfunction

    function automatic res_t exp_trap(input logic [31:0] epc, input logic [31:0] ms_new,
                                      input logic [31:0] cause, input logic [31:0] tvec);
        res_t r = blank();
        r.hold_cycles = 5; r.nwr = 3; r.first_wr = 2;
        r.wa[0] = 32'h341; r.wd[0] = epc;
        r.wa[1] = 32'h300; r.wd[1] = ms_new;
        r.wa[2] = 32'h342; r.wd[2] = cause;
        r.nassert = 1; r.assert_cyc = 5; r.assert_addr = tvec;
        return r;
    endfunction

    function automatic res_t exp_mret(input logic [31:0] ms_new, input logic [31:0] mepc);
        res_t r = blank();
        r.hold_cycles = 3; r.nwr = 1; r.first_wr = 2;
        r.wa[0] = 32'h300; r.wd[0] = ms_new;
        r.nassert = 1; r.assert_cyc = 3; r.assert_addr = mepc;
        return r;
    endfunction

    // Reference: what one request does, straight from the architectural rules
    function automatic res_t model(input stim_t s);
        logic        is_sync = (s.inst == ECALL) || (s.inst == EBREAK);
        logic        is_mret = (s.inst == MRET);
        logic        is_irq  = (s.int_flag != 8'h00) && s.mie && !s.div;
        logic [31:0] ms      = s.mstatus;
        if (is_sync || (!is_mret && is_irq)) begin
            ms[7] = s.mstatus[3];
            ms[3] = 1'b0;
            return exp_trap(is_sync ? s.inst_addr : (s.jump_flag ? s.jump_addr : s.inst_addr), ms,
                            is_sync ? ((s.inst == ECALL) ? 32'd11 : 32'd3) : EXT, s.mtvec);
        end
        if (is_mret) begin
            ms[3] = s.mstatus[7];
            ms[7] = 1'b1;
            return exp_mret(ms, s.mepc);
        end
        return blank();
    endfunction

    task automatic drive(input stim_t s);
        bus.inst_i          = s.inst;
        bus.inst_addr_i     = s.inst_addr;
        bus.int_flag_i      = s.int_flag;
        bus.global_int_en_i = s.mie;
        bus.div_started_i   = s.div;
        bus.jump_flag_i     = s.jump_flag;
        bus.jump_addr_i     = s.jump_addr;
        bus.csr_mstatus_i   = s.mstatus;
        bus.csr_mtvec_i     = s.mtvec;
        bus.csr_mepc_i      = s.mepc;
    endtask

    task automatic quiet_inputs();
        bus.inst_i      = NOP;
        bus.int_flag_i  = 8'h00;
        bus.jump_flag_i = 1'b0;
    endtask

    // Present one request for a cycle, then observe the following window
    task automatic run_txn(input stim_t s, output res_t r);
        r = blank();
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            if (c == 0) drive(s);
            if (c == 1) quiet_inputs();
            #1;
            if (bus.hold_flag_o) r.hold_cycles++;
            if (bus.we_o) begin
                if (r.nwr < 3) begin
                    r.wa[r.nwr] = bus.waddr_o;
                    r.wd[r.nwr] = bus.data_o;
                end
                if (r.first_wr < 0) r.first_wr = c;
                r.nwr++;
            end
            if (bus.int_assert_o) begin
                r.nassert++;
                r.assert_cyc  = c;
                r.assert_addr = bus.int_addr_o;
            end else if (bus.int_addr_o != 32'h0) begin
                r.leak++;
            end
        end
    endtask

    task automatic compare(input string tag, input res_t a, input res_t e);
        check({tag, "_hold"},     32'(a.hold_cycles), 32'(e.hold_cycles));
        check({tag, "_nwr"},      32'(a.nwr),         32'(e.nwr));
        check({tag, "_addrleak"}, 32'(a.leak),        32'(e.leak));
        for (int i = 0; i < e.nwr && i < 3; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), a.wa[i], e.wa[i]);
            check($sformatf("%s_wdata%0d", tag, i), a.wd[i], e.wd[i]);
        end
        check({tag, "_firstwr"},  32'(a.first_wr),    32'(e.first_wr));
        check({tag, "_nassert"},  32'(a.nassert),     32'(e.nassert));
        if (e.nassert > 0) begin
            check({tag, "_assertcyc"},  32'(a.assert_cyc), 32'(e.assert_cyc));
            check({tag, "_assertaddr"}, a.assert_addr,     e.assert_addr);
        end
    endtask

    // Count cycles in which the sequencer shows any activity
    task automatic count_busy(input int n, output int busy);
        busy = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            if (bus.hold_flag_o || bus.we_o || bus.int_assert_o) busy++;
        end
    endtask

    vec_t  tbl[11];
    res_t  got;
    stim_t s;
    int    busy;

    initial begin
        rst = 1'b0;
        drive(st(NOP, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
        repeat (3) @(negedge clk);
        #1;
        check("rst_we",       32'(bus.we_o),         32'h0);
        check("rst_waddr",    bus.waddr_o,           32'h0);
        check("rst_data",     bus.data_o,            32'h0);
        check("rst_assert",   32'(bus.int_assert_o), 32'h0);
        check("rst_int_addr", bus.int_addr_o,        32'h0);
        check("rst_hold",     32'(bus.hold_flag_o),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        tbl[0]  = '{st(ECALL,  32'h100,  8'h00, 1, 0, 0, 32'h0,   32'h8,         32'h400,       32'h0),
                    exp_trap(32'h100, 32'h80, 32'd11, 32'h400)};
        tbl[1]  = '{st(EBREAK, 32'h2000, 8'h00, 0, 0, 0, 32'h0,   32'h1888,      32'h8000_0000, 32'h0),
                    exp_trap(32'h2000, 32'h1880, 32'd3, 32'h8000_0000)};
        tbl[2]  = '{st(NOP,    32'h150,  8'h01, 1, 0, 1, 32'h200, 32'h8,         32'h400,       32'h0),
                    exp_trap(32'h200, 32'h80, EXT, 32'h400)};
        tbl[3]  = '{st(NOP,    32'h300,  8'h80, 1, 0, 0, 32'h0,   32'hFFFF_FF7F, 32'h1234_5600, 32'h0),
                    exp_trap(32'h300, 32'hFFFF_FFF7, EXT, 32'h1234_5600)};
        tbl[4]  = '{st(NOP,    32'h300,  8'h01, 0, 0, 0, 32'h0,   32'h0,         32'h400,       32'h0), blank()};
        tbl[5]  = '{st(NOP,    32'h300,  8'h01, 1, 1, 0, 32'h0,   32'h8,         32'h400,       32'h0), blank()};
        tbl[6]  = '{st(MRET,   32'h120,  8'h00, 0, 0, 0, 32'h0,   32'h80,        32'h400,       32'h104),
                    exp_mret(32'h88, 32'h104)};
        tbl[7]  = '{st(MRET,   32'h120,  8'h00, 0, 0, 0, 32'h0,   32'h1800,      32'h400,       32'hDEAD_BEE0),
                    exp_mret(32'h1880, 32'hDEAD_BEE0)};
        tbl[8]  = '{st(ECALL,  32'h500,  8'h01, 1, 0, 1, 32'h900, 32'h8,         32'h400,       32'h0),
                    exp_trap(32'h500, 32'h80, 32'd11, 32'h400)};
        tbl[9]  = '{st(32'h1050_0073, 32'h40, 8'h00, 1, 0, 0, 32'h0, 32'h8,      32'h400,       32'h0), blank()};
        tbl[10] = '{st(MRET,   32'h60,   8'h04, 1, 0, 0, 32'h0,   32'h88,        32'h400,       32'h40),
                    exp_mret(32'h88, 32'h40)};

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].s, got);
            compare($sformatf("vec%0d", i), got, tbl[i].e);
        end

        // Reset in the middle of the save sequence abandons it
        s = st(ECALL, 32'h700, 8'h00, 1, 0, 0, 32'h0, 32'h8, 32'h400, 32'h0);
        @(negedge clk);
        drive(s);
        @(negedge clk);
        quiet_inputs();
        @(negedge clk);
        #1;
        check("midrst_pre_we", 32'(bus.we_o), 32'h1);
        rst = 1'b0;
        #1;
        check("midrst_we",       32'(bus.we_o),         32'h0);
        check("midrst_waddr",    bus.waddr_o,           32'h0);
        check("midrst_data",     bus.data_o,            32'h0);
        check("midrst_assert",   32'(bus.int_assert_o), 32'h0);
        check("midrst_int_addr", bus.int_addr_o,        32'h0);
        check("midrst_hold",     32'(bus.hold_flag_o),  32'h0);
        @(negedge clk);
        rst = 1'b1;
        count_busy(8, busy);
        check("midrst_residual", 32'(busy), 32'h0);

        // Interrupt deferred while a divide is in flight, taken once it ends
        s = st(NOP, 32'h600, 8'h01, 1, 1, 0, 32'h0, 32'h8, 32'h400, 32'h0);
        @(negedge clk);
        drive(s);
        count_busy(4, busy);
        check("div_defer_busy", 32'(busy), 32'h0);
        s.div = 1'b0;
        run_txn(s, got);
        compare("div_release", got, exp_trap(32'h600, 32'h80, EXT, 32'h400));

        // ECALL beats a simultaneous interrupt; interrupt waits for MIE
        s = st(ECALL, 32'h500, 8'h01, 1, 0, 1, 32'h900, 32'h8, 32'h400, 32'h0);
        run_txn(s, got);
        compare("simul_ecall", got, exp_trap(32'h500, 32'h80, 32'd11, 32'h400));
        @(negedge clk);
        drive(st(NOP, 32'h504, 8'h01, 0, 0, 0, 32'h0, 32'h80, 32'h400, 32'h0));
        count_busy(6, busy);
        check("simul_pending_busy", 32'(busy), 32'h0);
        s = st(NOP, 32'h504, 8'h01, 1, 0, 0, 32'h0, 32'h88, 32'h400, 32'h0);
        run_txn(s, got);
        compare("simul_irq", got, exp_trap(32'h504, 32'h80, EXT, 32'h400));

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0:       s.inst = ECALL;
                1:       s.inst = EBREAK;
                2:       s.inst = MRET;
                default: s.inst = $urandom;
            endcase
            s.inst_addr = $urandom & 32'hFFFF_FFFC;
            s.int_flag  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            s.mie       = 1'($urandom);
            s.div       = ($urandom_range(0, 3) == 0);
            s.jump_flag = 1'($urandom);
            s.jump_addr = $urandom & 32'hFFFF_FFFC;
            s.mstatus   = $urandom;
            s.mtvec     = $urandom & 32'hFFFF_FFFC;
            s.mepc      = $urandom & 32'hFFFF_FFFC;
            run_txn(s, got);
            compare($sformatf("rnd%0d", n), got, model(s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
